// File: rtl/mux_n_1_rr_if.sv
// Bundle of the N-channel input side and single output side of the mux.
// The mux uses the slave modport; whatever drives and observes it uses master.
interface mux_n_1_rr_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SW-1:0]      sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SW-1:0]      out_ch;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/mux_n_1_rr.sv
// N:1 valid/ready multiplexer with a registered output stage.
// The channel is picked either by a fixed select or by a round-robin pointer.
module mux_n_1_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    mux_n_1_rr_if.slave      bus
);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    logic [WIDTH-1:0] word [N];
    logic [N-1:0]     grant;
    logic [SW-1:0]    grant_idx;
    logic             any_grant;
    logic             load_en;
    int               idx;

    assign load_en = !out_valid_q || bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign word[gi]         = bus.in_data[gi*WIDTH +: WIDTH];
            assign bus.in_ready[gi] = load_en && grant[gi] && !rst;
        end
    endgenerate

    // Grant is derived from in_valid and the pointer only, never from data.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        if (!bus.mode) begin
            if (int'(bus.sel) < N) begin
                if (bus.in_valid[bus.sel]) begin
                    any_grant = 1'b1;
                    grant_idx = bus.sel;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr_q) + k) % N;
                if (!any_grant && bus.in_valid[idx]) begin
                    any_grant = 1'b1;
                    grant_idx = SW'(idx);
                end
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (any_grant) begin
                out_data_d  = word[grant_idx];
                out_ch_d    = grant_idx;
                out_valid_d = 1'b1;
                if (bus.mode) begin
                    ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_n_1_rr.sv
// Directed bench: a per-cycle vector table on a 4-channel mux, plus a short
// hand sequence on a 3-channel mux for the out-of-range select.
module tb_mux_n_1_rr;
    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    mux_n_1_rr_if #(.WIDTH(8), .N(4)) bus4 ();
    mux_n_1_rr_if #(.WIDTH(8), .N(3)) bus3 ();

    mux_n_1_rr #(.WIDTH(8), .N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mux_n_1_rr #(.WIDTH(8), .N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        logic       rst;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] v;
        logic       r;
        logic [3:0] ir;
        logic       ov;
        logic [7:0] od;
        logic [1:0] oc;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(logic rs, logic m, logic [1:0] s, logic [3:0] v,
                                logic r, logic [3:0] ir, logic ov,
                                logic [7:0] od, logic [1:0] oc);
        vec_t t;
        t.rst = rs; t.mode = m; t.sel = s; t.v = v; t.r = r;
        t.ir = ir; t.ov = ov; t.od = od; t.oc = oc;
        return t;
    endfunction

    task automatic check(string name, int step, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    initial begin
        // Output columns describe the state seen before the edge that ends the row.
        vecs[0]  = mk(1, 1, 0, 4'hF, 1, 4'b0000, 0, 8'h00, 0);
        vecs[1]  = mk(0, 0, 2, 4'hF, 1, 4'b0100, 0, 8'h00, 0);
        vecs[2]  = mk(0, 0, 2, 4'hF, 1, 4'b0100, 1, 8'h33, 2);
        vecs[3]  = mk(0, 1, 0, 4'hF, 1, 4'b0001, 1, 8'h33, 2);
        vecs[4]  = mk(0, 1, 0, 4'hF, 1, 4'b0010, 1, 8'h11, 0);
        vecs[5]  = mk(0, 1, 0, 4'hF, 1, 4'b0100, 1, 8'h22, 1);
        vecs[6]  = mk(0, 1, 0, 4'hF, 1, 4'b1000, 1, 8'h33, 2);
        vecs[7]  = mk(0, 1, 0, 4'hF, 1, 4'b0001, 1, 8'h44, 3);
        vecs[8]  = mk(0, 1, 0, 4'hF, 1, 4'b0010, 1, 8'h11, 0);
        vecs[9]  = mk(0, 1, 0, 4'hF, 1, 4'b0100, 1, 8'h22, 1);
        vecs[10] = mk(0, 1, 0, 4'hF, 1, 4'b1000, 1, 8'h33, 2);
        vecs[11] = mk(0, 1, 0, 4'hF, 0, 4'b0000, 1, 8'h44, 3);
        vecs[12] = mk(0, 1, 0, 4'hF, 0, 4'b0000, 1, 8'h44, 3);
        vecs[13] = mk(0, 1, 0, 4'hF, 0, 4'b0000, 1, 8'h44, 3);
        vecs[14] = mk(0, 1, 0, 4'hF, 1, 4'b0001, 1, 8'h44, 3);
        vecs[15] = mk(0, 1, 0, 4'b0100, 1, 4'b0100, 1, 8'h11, 0);
        vecs[16] = mk(0, 1, 0, 4'b0010, 1, 4'b0010, 1, 8'h33, 2);
        vecs[17] = mk(0, 1, 0, 4'b0000, 1, 4'b0000, 1, 8'h22, 1);
        vecs[18] = mk(0, 1, 0, 4'b0000, 1, 4'b0000, 0, 8'h22, 1);
        vecs[19] = mk(0, 1, 0, 4'b1011, 0, 4'b1000, 0, 8'h22, 1);
        vecs[20] = mk(0, 0, 1, 4'b1011, 0, 4'b0000, 1, 8'h44, 3);
        vecs[21] = mk(0, 0, 1, 4'b1011, 1, 4'b0010, 1, 8'h44, 3);
        vecs[22] = mk(0, 0, 2, 4'b1011, 1, 4'b0000, 1, 8'h22, 1);
        vecs[23] = mk(0, 1, 0, 4'hF, 1, 4'b0001, 0, 8'h22, 1);
        vecs[24] = mk(1, 1, 0, 4'hF, 1, 4'b0000, 1, 8'h11, 0);
        vecs[25] = mk(0, 1, 0, 4'hF, 0, 4'b0001, 0, 8'h00, 0);

        bus4.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus4.in_valid  = 4'hF;
        bus4.mode      = 1'b1;
        bus4.sel       = '0;
        bus4.out_ready = 1'b1;
        bus3.in_data   = {8'h33, 8'h22, 8'h11};
        bus3.in_valid  = 3'b000;
        bus3.mode      = 1'b0;
        bus3.sel       = '0;
        bus3.out_ready = 1'b1;
        rst            = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            bus4.mode      = vecs[i].mode;
            bus4.sel       = vecs[i].sel;
            bus4.in_valid  = vecs[i].v;
            bus4.out_ready = vecs[i].r;
            #1;
            check("in_ready",  i, 32'(bus4.in_ready),  32'(vecs[i].ir));
            check("out_valid", i, 32'(bus4.out_valid), 32'(vecs[i].ov));
            check("out_data",  i, 32'(bus4.out_data),  32'(vecs[i].od));
            check("out_ch",    i, 32'(bus4.out_ch),    32'(vecs[i].oc));
            $display("vec %0d: rst=%0b mode=%0b sel=%0d v=%b r=%0b -> ir=%b ov=%0b od=%h ch=%0d",
                     i, rst, bus4.mode, bus4.sel, bus4.in_valid, bus4.out_ready,
                     bus4.in_ready, bus4.out_valid, bus4.out_data, bus4.out_ch);
        end

        // Three-channel mux: load channel 0, then select the nonexistent channel 3.
        @(negedge clk);
        bus3.mode = 1'b0; bus3.sel = 2'd0; bus3.in_valid = 3'b111; bus3.out_ready = 1'b0;
        #1;
        check("n3_load_ready", 100, 32'(bus3.in_ready),  32'b001);
        check("n3_load_ov",    100, 32'(bus3.out_valid), 32'd0);
        @(negedge clk);
        bus3.sel = 2'd3;
        #1;
        check("n3_hold_ready", 101, 32'(bus3.in_ready),  32'b000);
        check("n3_hold_ov",    101, 32'(bus3.out_valid), 32'd1);
        check("n3_hold_data",  101, 32'(bus3.out_data),  32'h11);
        @(negedge clk);
        bus3.out_ready = 1'b1;
        #1;
        check("n3_oor_ready",  102, 32'(bus3.in_ready),  32'b000);
        check("n3_oor_ov",     102, 32'(bus3.out_valid), 32'd1);
        @(negedge clk);
        #1;
        check("n3_drain_ready", 103, 32'(bus3.in_ready),  32'b000);
        check("n3_drain_ov",    103, 32'(bus3.out_valid), 32'd0);
        check("n3_drain_data",  103, 32'(bus3.out_data),  32'h11);
        check("n3_drain_ch",    103, 32'(bus3.out_ch),    32'd0);
        $display("n3 seq: sel=3 ir=%b ov=%0b od=%h ch=%0d",
                 bus3.in_ready, bus3.out_valid, bus3.out_data, bus3.out_ch);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
